// File: rtl/mips_prog_loader.sv
// Boot/dump sequencer for the two-phase MIPS core: streams a program into imem, pulses start,
// waits for HALT, then streams R0..R[NREGS_DUMP-1] out. Optional watchdog under LOADER_TIMEOUT_EN.
module mips_prog_loader #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int REG_AW      = 5,
    parameter int NREGS_DUMP  = 6,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              cmd_start,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_start,
    output logic              core_run,
    input  logic              core_halted,
    output logic [REG_AW-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [REG_AW-1:0] dump_idx,
    output logic              dump_last,
    output logic              busy,
    output logic              done,
    output logic              err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_DUMP,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(NREGS_DUMP - 1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [REG_AW-1:0] idx_reg, idx_next;
    logic              run_first_reg, run_first_next;

`ifdef LOADER_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    logic [WD_W-1:0] wd_reg, wd_next;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

    // Write data and dump data are pure pass-throughs; the strobes qualify them.
    assign imem_wdata = ld_data;
    assign dump_data  = rf_rdata;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            addr_reg      <= '0;
            idx_reg       <= '0;
            run_first_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            idx_reg       <= idx_next;
            run_first_reg <= run_first_next;
        end
    end

`ifdef LOADER_TIMEOUT_EN
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            wd_reg <= '0;
        end else begin
            wd_reg <= wd_next;
        end
    end
`endif

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        idx_next       = idx_reg;
        run_first_next = run_first_reg;
`ifdef LOADER_TIMEOUT_EN
        wd_next        = wd_reg;
`endif
        ld_ready       = 1'b0;
        imem_we        = 1'b0;
        imem_addr      = '0;
        core_start     = 1'b0;
        core_run       = 1'b0;
        rf_raddr       = '0;
        dump_valid     = 1'b0;
        dump_idx       = '0;
        dump_last      = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        err_timeout    = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (cmd_start) begin
                    addr_next  = '0;
                    state_next = S_LOAD;
                end
            end

            S_LOAD: begin
                busy      = 1'b1;
                ld_ready  = 1'b1;
                imem_addr = addr_reg;
                if (ld_valid) begin
                    imem_we   = 1'b1;
                    addr_next = addr_reg + 1'b1;
                    // Stop at the top word instead of wrapping over address 0.
                    if (ld_last || (addr_reg == ADDR_MAX)) begin
                        state_next = S_START;
                    end
                end
            end

            S_START: begin
                busy           = 1'b1;
                core_start     = 1'b1;
                run_first_next = 1'b1;
`ifdef LOADER_TIMEOUT_EN
                wd_next        = '0;
`endif
                state_next     = S_RUN;
            end

            S_RUN: begin
                busy           = 1'b1;
                core_run       = 1'b1;
                run_first_next = 1'b0;
                // The halted flag may still be stale in the first RUN cycle.
                if (!run_first_reg && core_halted) begin
                    idx_next   = '0;
                    state_next = S_DUMP;
                end
`ifdef LOADER_TIMEOUT_EN
                else if (wd_reg == WD_LAST) begin
                    state_next = S_ERR;
                end else begin
                    wd_next = wd_reg + 1'b1;
                end
`endif
            end

            S_DUMP: begin
                busy       = 1'b1;
                dump_valid = 1'b1;
                rf_raddr   = idx_reg;
                dump_idx   = idx_reg;
                dump_last  = (idx_reg == LAST_IDX);
                if (dump_ready) begin
                    idx_next = idx_reg + 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        state_next = S_DONE;
                    end
                end
            end

            S_DONE: begin
                done = 1'b1;
                if (cmd_start) begin
                    addr_next  = '0;
                    state_next = S_LOAD;
                end
            end

            S_ERR: begin
`ifdef LOADER_TIMEOUT_EN
                err_timeout = 1'b1;
`endif
                if (cmd_start) begin
                    addr_next  = '0;
                    state_next = S_LOAD;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule
